// File: rtl/a1csa_pipe.sv
// Two-stage pipelined add-one carry-select adder with add/sub mode and valid/ready on both sides.
// Stage 1 forms per-block carry-in-0 sums; stage 2 resolves block carries and applies add-one.
module a1csa_pipe #(
    parameter int unsigned N = 16,
    parameter int unsigned B = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int unsigned NB = (B == 0) ? 1 : N / B;

    if (B == 0 || (N % B) != 0 || N == 0) begin : g_param_check
        $error("a1csa_pipe: N must be a non-zero multiple of B");
    end

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic s2_free;
    logic s1_adv;
    logic in_xfer;

    always_comb begin
        s2_free  = !v2_q || out_ready;
        s1_adv   = v1_q && s2_free;
        in_ready = !v1_q || s2_free;
        in_xfer  = in_valid && in_ready;
        v2_d     = s1_adv ? 1'b1 : (out_ready ? 1'b0 : v2_q);
        v1_d     = in_xfer ? 1'b1 : (s1_adv ? 1'b0 : v1_q);
    end

    // ------------------------------------------------------------------
    // Stage 1: operand conditioning and per-block carry-in-0 sums
    // ------------------------------------------------------------------
    logic [N-1:0]  bb;
    logic          c0;
    logic [N-1:0]  s0_d;
    logic [NB-1:0] g_d;
    logic [NB-1:0] p_d;
    logic [B:0]    blk_sum;

    always_comb begin
        bb      = sub ? ~b : b;
        c0      = sub ? 1'b1 : cin;
        s0_d    = '0;
        g_d     = '0;
        p_d     = '0;
        blk_sum = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            blk_sum = {1'b0, a[k*B +: B]} + {1'b0, bb[k*B +: B]};
            s0_d[k*B +: B] = blk_sum[B-1:0];
            g_d[k] = blk_sum[B];
            // An all-ones block sum is the only case where carry-in 1 ripples out.
            p_d[k] = &blk_sum[B-1:0];
        end
    end

    logic [N-1:0]  s0_q;
    logic [NB-1:0] g_q;
    logic [NB-1:0] p_q;
    logic          c0_q;
    logic          a_msb_q;
    logic          bb_msb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            s0_q     <= '0;
            g_q      <= '0;
            p_q      <= '0;
            c0_q     <= 1'b0;
            a_msb_q  <= 1'b0;
            bb_msb_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            if (in_xfer) begin
                s0_q     <= s0_d;
                g_q      <= g_d;
                p_q      <= p_d;
                c0_q     <= c0;
                a_msb_q  <= a[N-1];
                bb_msb_q <= bb[N-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: block carry chain and add-one correction
    // ------------------------------------------------------------------
    logic [NB:0]  carry;
    logic [N-1:0] sum_d;
    logic         cout_d;
    logic         ovf_d;
    logic         run;

    always_comb begin
        carry    = '0;
        carry[0] = c0_q;
        for (int unsigned k = 0; k < NB; k++) begin
            carry[k+1] = g_q[k] | (p_q[k] & carry[k]);
        end
        sum_d = '0;
        run   = 1'b0;
        for (int unsigned k = 0; k < NB; k++) begin
            // Bit i flips when the block carry reaches it through all lower ones.
            run = carry[k];
            for (int unsigned j = 0; j < B; j++) begin
                sum_d[k*B+j] = s0_q[k*B+j] ^ run;
                run = run & s0_q[k*B+j];
            end
        end
        cout_d = carry[NB];
        ovf_d  = (a_msb_q == bb_msb_q) && (sum_d[N-1] != a_msb_q);
    end

    logic [N-1:0] sum_q;
    logic         cout_q;
    logic         ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q   <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            v2_q <= v2_d;
            if (s1_adv) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = v2_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_a1csa_pipe.sv
// Self-checking bench for a1csa_pipe: directed corner cases, backpressure, reset, random traffic.
// Expected results come from a signed/unsigned integer model of a+b+cin and a-b.
module tb_a1csa_pipe;

    localparam int unsigned N = 16;
    localparam int unsigned B = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    int errors = 0;
    int checks = 0;

    a1csa_pipe #(.N(N), .B(B)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {ovf, cout, sum} from integer arithmetic on the operands.
    function automatic logic [N+1:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                           input logic mcin, input logic msub);
        longint m, ua, ub, sa, sb, res_u, res_s;
        logic   mc, mo;
        m  = longint'(1) << N;
        ua = longint'(ma);
        ub = longint'(mb);
        sa = ma[N-1] ? ua - m : ua;
        sb = mb[N-1] ? ub - m : ub;
        if (!msub) begin
            res_u = ua + ub + longint'(mcin);
            res_s = sa + sb + longint'(mcin);
            mc    = (res_u >= m);
        end else begin
            res_u = ua - ub;
            res_s = sa - sb;
            mc    = (ua >= ub);
        end
        mo = (res_s >= m / 2) || (res_s < -(m / 2));
        return {mo, mc, res_u[N-1:0]};
    endfunction

    task automatic drive_idle();
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
    endtask

    // Sends one operation into an empty pipe and samples the result two edges later.
    task automatic run_one(input logic [N-1:0] ta, input logic [N-1:0] tb_op, input logic tcin,
                           input logic tsub, output logic [N-1:0] rs, output logic rc,
                           output logic ro, output logic rv1, output logic rv2);
        @(posedge clk); #1;
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_op;
        cin       = tcin;
        sub       = tsub;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 'x;
        b        = 'x;
        @(negedge clk);
        rv1 = out_valid;
        @(posedge clk);
        @(negedge clk);
        rv2 = out_valid;
        rs  = sum;
        rc  = cout;
        ro  = ovf;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        out_ready = 1'b0;
        drive_idle();
        #12;
        checks++;
        if ({out_valid, sum, cout, ovf} !== {1'b0, {N{1'b0}}, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b, want all zero",
                     out_valid, sum, cout, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [N-1:0] va [6] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'hFFFF};
        logic [N-1:0] vb [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0000};
        logic         vc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic         vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [N-1:0] es [6] = '{16'h0100, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h0000};
        logic         ec [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic         eo [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [N-1:0] rs;
        logic         rc, ro, rv1, rv2;
        for (int i = 0; i < 6; i++) begin
            run_one(va[i], vb[i], vc[i], vs[i], rs, rc, ro, rv1, rv2);
            checks++;
            if (rv1 !== 1'b0 || rv2 !== 1'b1) begin
                errors++;
                $display("FAIL directed_latency[%0d]: valid after 1 edge=%b, 2 edges=%b, want 0,1",
                         i, rv1, rv2);
            end
            checks++;
            if ({rs, rc, ro} !== {es[i], ec[i], eo[i]}) begin
                errors++;
                $display("FAIL directed_result[%0d]: got sum=%h cout=%b ovf=%b, want %h %b %b",
                         i, rs, rc, ro, es[i], ec[i], eo[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [N+1:0] exp_q[$];
        logic [N+1:0] e;
        logic [N-1:0] va [4] = '{16'h1234, 16'hFFF0, 16'h8001, 16'h0F0F};
        logic [N-1:0] vb [4] = '{16'h4321, 16'h0020, 16'h0002, 16'hF0F0};
        logic         vs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int n_in  = 0;
        int n_out = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            out_ready = (c >= 3);
            in_valid  = (n_in < 4);
            if (n_in < 4) begin
                a   = va[n_in];
                b   = vb[n_in];
                sub = vs[n_in];
                cin = 1'b1;
            end
            @(negedge clk);
            if (c < 3) begin
                checks++;
                if (in_ready !== (c < 2)) begin
                    errors++;
                    $display("FAIL b2b_in_ready[c=%0d]: got %b, want %b", c, in_ready, c < 2);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                n_in++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra_output: got sum=%h with nothing outstanding", sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({ovf, cout, sum} !== e) begin
                        errors++;
                        $display("FAIL b2b_result[%0d]: got {ovf,cout,sum}=%h, want %h",
                                 n_out, {ovf, cout, sum}, e);
                    end
                end
                n_out++;
            end
        end
        checks++;
        if (n_in != 4 || n_out != 4) begin
            errors++;
            $display("FAIL b2b_count: accepted %0d emitted %0d, want 4 and 4", n_in, n_out);
        end
        drive_idle();
    endtask

    task automatic test_reset_midflight();
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 16'h0101;
        b         = 16'h0202;
        @(posedge clk); #1;
        a = 16'h0303;
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_full: got out_valid=%b in_ready=%b, want 1 0",
                     out_valid, in_ready);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== '0) begin
            errors++;
            $display("FAIL midrst_async: got out_valid=%b in_ready=%b sum=%h, want 0 1 0",
                     out_valid, in_ready, sum);
        end
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_stale[c=%0d]: got out_valid=%b sum=%h, want 0",
                         c, out_valid, sum);
            end
        end
    endtask

    task automatic test_random();
        logic [N+1:0] exp_q[$];
        logic [N+1:0] e;
        logic [N+1:0] held;
        logic         stalled = 1'b0;
        int           n_out = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if (c < 3900) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                a         = N'($urandom);
                b         = N'($urandom);
                cin       = 1'($urandom);
                sub       = 1'($urandom);
                out_ready = ($urandom_range(0, 9) < 6);
            end else begin
                drive_idle();
                out_ready = 1'b1;
            end
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || {ovf, cout, sum} !== held) begin
                    errors++;
                    $display("FAIL rand_hold[c=%0d]: got valid=%b {ovf,cout,sum}=%h, want 1 %h",
                             c, out_valid, {ovf, cout, sum}, held);
                end
            end
            stalled = out_valid && !out_ready;
            held    = {ovf, cout, sum};
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra_output[c=%0d]: sum=%h with nothing outstanding",
                             c, sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({ovf, cout, sum} !== e) begin
                        errors++;
                        $display("FAIL rand_result[%0d]: got {ovf,cout,sum}=%h, want %h",
                                 n_out, {ovf, cout, sum}, e);
                    end
                end
                n_out++;
            end
        end
        checks++;
        if (exp_q.size() != 0 || n_out < 1000) begin
            errors++;
            $display("FAIL rand_drain: %0d results left outstanding, %0d emitted",
                     exp_q.size(), n_out);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
